// File: rtl/pcileech_ft601_responder.sv
// pcileech_ft601_responder
// Device-side model of the FT601 245-synchronous FIFO bus. It sits opposite
// the FPGA-side master and is used for loopback bring-up and self-test.
//   RX path : host_din push port -> RX FIFO -> ft601_data_out (first-word
//             fall-through), popped by the master with rd_n/oe_n.
//   TX path : master writes {be,data} under wr_n -> TX FIFO -> host_dout pop port.
//   Flags   : ft601_rxf_n / ft601_txe_n are registered from next-cycle counts.
//   Errors  : sticky underrun / overrun / contention flags, cleared by rst.
// Ports: clk, rst (async, active high), ft601_* bus signals, host_din* push
// port, host_dout* pop port, err_* flags, rx_count / tx_count occupancy.
module pcileech_ft601_responder #(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              ft601_data_in,
  input  logic [3:0]               ft601_be_in,
  output logic [31:0]              ft601_data_out,
  output logic                     ft601_data_oe,
  output logic                     ft601_rxf_n,
  output logic                     ft601_txe_n,
  input  logic                     ft601_wr_n,
  input  logic                     ft601_rd_n,
  input  logic                     ft601_oe_n,
  input  logic                     ft601_siwu_n,
  input  logic [31:0]              host_din,
  input  logic                     host_din_valid,
  output logic                     host_din_ready,
  output logic [35:0]              host_dout,
  output logic                     host_dout_valid,
  input  logic                     host_dout_ready,
  output logic                     err_underrun,
  output logic                     err_overrun,
  output logic                     err_contention,
  output logic [RX_DEPTH_LOG2:0]   rx_count,
  output logic [TX_DEPTH_LOG2:0]   tx_count
);
  localparam int RA  = RX_DEPTH_LOG2;
  localparam int TA  = TX_DEPTH_LOG2;
  localparam int RXD = 1 << RA;
  localparam int TXD = 1 << TA;
  localparam logic [RA:0] RX_FULL = RXD[RA:0];
  localparam logic [TA:0] TX_FULL = TXD[TA:0];

  typedef enum logic [1:0] {S_IDLE, S_RD_ARB, S_RD, S_WR} state_t;
  state_t state_q, state_d;

  logic [31:0] rx_mem [RXD];
  logic [35:0] tx_mem [TXD];

  logic [RA:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d, rx_count_d;
  logic [TA:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, tx_count_d;
  logic        rxf_n_q, rxf_n_d, txe_n_q, txe_n_d;
  logic        under_q, under_d, over_q, over_d, cont_q, cont_d;
  logic        rx_push, rx_pop, tx_push, tx_pop;

  // siwu_n has no function in this model
  logic unused_siwu;
  assign unused_siwu = ft601_siwu_n;

  assign rx_count = rx_wp_q - rx_rp_q;
  assign tx_count = tx_wp_q - tx_rp_q;

  // Readiness depends only on the current count: a same-cycle pop never
  // makes room for a push into a full FIFO.
  assign host_din_ready  = ~rst & (rx_count != RX_FULL);
  assign host_dout_valid = (tx_count != '0);

  assign rx_push = host_din_valid & host_din_ready;
  assign rx_pop  = ~ft601_rd_n & ~ft601_oe_n & ~rxf_n_q;
  assign tx_push = ~ft601_wr_n & ~txe_n_q;
  assign tx_pop  = host_dout_valid & host_dout_ready;

  assign ft601_data_out = (rx_count != '0) ? rx_mem[rx_rp_q[RA-1:0]] : 32'h0;
  assign ft601_data_oe  = ~ft601_oe_n & ~rst;
  assign host_dout      = host_dout_valid ? tx_mem[tx_rp_q[TA-1:0]] : 36'h0;

  assign ft601_rxf_n    = rxf_n_q;
  assign ft601_txe_n    = txe_n_q;
  assign err_underrun   = under_q;
  assign err_overrun    = over_q;
  assign err_contention = cont_q;

  always_comb begin
    rx_wp_d    = rx_wp_q + (RA+1)'(rx_push);
    rx_rp_d    = rx_rp_q + (RA+1)'(rx_pop);
    tx_wp_d    = tx_wp_q + (TA+1)'(tx_push);
    tx_rp_d    = tx_rp_q + (TA+1)'(tx_pop);
    rx_count_d = rx_wp_d - rx_rp_d;
    tx_count_d = tx_wp_d - tx_rp_d;
    // Registered from next-cycle counts so the flags never overshoot.
    rxf_n_d    = (rx_count_d == '0);
    txe_n_d    = (tx_count_d == TX_FULL);
    under_d    = under_q | (~ft601_rd_n & ~ft601_oe_n & rxf_n_q);
    over_d     = over_q  | (~ft601_wr_n & txe_n_q);
    cont_d     = cont_q  | (~ft601_oe_n & ~ft601_wr_n)
                         | ((state_q == S_WR) & ~ft601_oe_n);
  end

  // Bus phase tracker; an output enable while the master is writing is
  // contention and does not leave WR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (~ft601_oe_n) state_d = S_RD_ARB;
                else if (~ft601_wr_n) state_d = S_WR;
      S_RD_ARB: if (ft601_oe_n) state_d = S_IDLE;
                else if (~ft601_rd_n) state_d = S_RD;
      S_RD:     if (ft601_oe_n) state_d = S_IDLE;
      S_WR:     if (ft601_wr_n) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rxf_n_q <= 1'b1;
      txe_n_q <= 1'b1;
      under_q <= 1'b0;
      over_q  <= 1'b0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
      rxf_n_q <= rxf_n_d;
      txe_n_q <= txe_n_d;
      under_q <= under_d;
      over_q  <= over_d;
      cont_q  <= cont_d;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp_q[RA-1:0]] <= host_din;
    if (tx_push) tx_mem[tx_wp_q[TA-1:0]] <= {ft601_be_in, ft601_data_in};
  end
endmodule

// File: tb/tb_pcileech_ft601_responder.sv
module tb_pcileech_ft601_responder;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] ft601_data_in = '0, ft601_data_out, host_din = '0;
  logic [3:0]  ft601_be_in = '0;
  logic        ft601_data_oe, ft601_rxf_n, ft601_txe_n;
  logic        ft601_wr_n = 1'b1, ft601_rd_n = 1'b1, ft601_oe_n = 1'b1, ft601_siwu_n = 1'b1;
  logic        host_din_valid = 1'b0, host_din_ready;
  logic [35:0] host_dout;
  logic        host_dout_valid, host_dout_ready = 1'b0;
  logic        err_underrun, err_overrun, err_contention;
  logic [4:0]  rx_count, tx_count;

  pcileech_ft601_responder dut (
    .clk(clk), .rst(rst),
    .ft601_data_in(ft601_data_in), .ft601_be_in(ft601_be_in),
    .ft601_data_out(ft601_data_out), .ft601_data_oe(ft601_data_oe),
    .ft601_rxf_n(ft601_rxf_n), .ft601_txe_n(ft601_txe_n),
    .ft601_wr_n(ft601_wr_n), .ft601_rd_n(ft601_rd_n), .ft601_oe_n(ft601_oe_n),
    .ft601_siwu_n(ft601_siwu_n),
    .host_din(host_din), .host_din_valid(host_din_valid), .host_din_ready(host_din_ready),
    .host_dout(host_dout), .host_dout_valid(host_dout_valid), .host_dout_ready(host_dout_ready),
    .err_underrun(err_underrun), .err_overrun(err_overrun), .err_contention(err_contention),
    .rx_count(rx_count), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  // Reference model: word queues plus occupancy and sticky flags.
  logic [31:0] rx_q[$];
  logic [35:0] tx_q[$];
  int rx_n = 0, tx_n = 0;
  bit e_under = 0, e_over = 0, e_cont = 0;
  int vecs = 0, errs = 0;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    ft601_wr_n = 1; ft601_rd_n = 1; ft601_oe_n = 1;
    host_din_valid = 0; host_dout_ready = 0;
  endtask

  // Apply the currently driven inputs for one clock, updating the model.
  task automatic step();
    bit rd, rd_ok, push_ok, wr_ok, pop_ok;
    rd      = !ft601_rd_n && !ft601_oe_n;
    rd_ok   = rd && rx_n != 0;
    push_ok = host_din_valid && rx_n != 16;
    wr_ok   = !ft601_wr_n && tx_n != 16;
    pop_ok  = host_dout_ready && tx_n != 0;
    if (push_ok) rx_q.push_back(host_din);
    if (wr_ok)   tx_q.push_back({ft601_be_in, ft601_data_in});
    if (rd && rx_n == 0)          e_under = 1;
    if (!ft601_wr_n && tx_n == 16) e_over = 1;
    if (!ft601_oe_n && !ft601_wr_n) e_cont = 1;
    rx_n = rx_n + int'(push_ok) - int'(rd_ok);
    tx_n = tx_n + int'(wr_ok) - int'(pop_ok);
    @(posedge clk); #1;
    chk("rx_count", 36'(rx_count), 36'(rx_n));
    chk("tx_count", 36'(tx_count), 36'(tx_n));
    chk("rxf_n", 36'(ft601_rxf_n), 36'(rx_n == 0));
    chk("txe_n", 36'(ft601_txe_n), 36'(tx_n == 16));
    chk("din_ready", 36'(host_din_ready), 36'(rx_n != 16));
    chk("dout_valid", 36'(host_dout_valid), 36'(tx_n != 0));
    chk("err_underrun", 36'(err_underrun), 36'(e_under));
    chk("err_overrun", 36'(err_overrun), 36'(e_over));
    chk("err_contention", 36'(err_contention), 36'(e_cont));
    chk("data_oe", 36'(ft601_data_oe), 36'(!ft601_oe_n));
  endtask

  task automatic chk_reset();
    chk("rst_rxf_n", 36'(ft601_rxf_n), 36'(1));
    chk("rst_txe_n", 36'(ft601_txe_n), 36'(1));
    chk("rst_data_oe", 36'(ft601_data_oe), 36'(0));
    chk("rst_data_out", 36'(ft601_data_out), 36'(0));
    chk("rst_din_ready", 36'(host_din_ready), 36'(0));
    chk("rst_dout_valid", 36'(host_dout_valid), 36'(0));
    chk("rst_errs", 36'({err_underrun, err_overrun, err_contention}), 36'(0));
    chk("rst_counts", 36'({rx_count, tx_count}), 36'(0));
  endtask

  // Monitor: compare every transfer the DUT presents against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst && !ft601_rd_n && !ft601_oe_n && !ft601_rxf_n) begin
      if (rx_q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL rx_read: got %h expected no read", ft601_data_out);
      end else chk("rx_read_data", 36'(ft601_data_out), 36'(rx_q.pop_front()));
    end
    if (!rst && host_dout_valid && host_dout_ready) begin
      if (tx_q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL tx_pop: got %h expected no pop", host_dout);
      end else chk("tx_pop_data", host_dout, tx_q.pop_front());
    end
  end

  initial begin
    bit prev_wr;
    int m;
    idle();
    repeat (2) @(posedge clk);
    #1 chk_reset();
    rst = 0;
    step();

    // 1: push three, read them back as a 3-cycle burst
    for (int i = 0; i < 3; i++) begin
      host_din_valid = 1; host_din = 32'hA000_0001 + 32'(i); step();
    end
    host_din_valid = 0;
    ft601_oe_n = 0; step();
    ft601_rd_n = 0; repeat (3) step();
    idle(); step();

    // 2: 16 writes fill TX, 17th overruns, then host drains in order
    for (int i = 0; i < 17; i++) begin
      ft601_wr_n = 0; ft601_data_in = 32'h100 + 32'(i); ft601_be_in = 4'hF; step();
    end
    idle(); step();
    host_dout_ready = 1; repeat (16) step();
    idle(); step();

    // 3: RX full, simultaneous push and read; push refused, oldest popped
    for (int i = 0; i < 16; i++) begin
      host_din_valid = 1; host_din = 32'hB00 + 32'(i); step();
    end
    host_din = 32'hDEAD_BEEF; ft601_oe_n = 0; ft601_rd_n = 0; step();
    idle(); step();

    // 4: oe_n and wr_n low together
    ft601_oe_n = 0; ft601_wr_n = 0; ft601_data_in = 32'h5A5A; ft601_be_in = 4'h3; step();
    idle(); repeat (2) step();

    // 5: 40 push+read cycles, pointers wrap twice
    host_din_valid = 1; ft601_oe_n = 0; ft601_rd_n = 0;
    for (int i = 0; i < 40; i++) begin
      host_din = 32'hC000 + 32'(i); step();
    end
    host_din_valid = 0;
    for (int i = 0; i < 20 && rx_n > 0; i++) step();
    idle(); host_dout_ready = 1;
    for (int i = 0; i < 20 && tx_n > 0; i++) step();
    idle(); step();

    // randomized mixed traffic; no output enable right after a write cycle
    prev_wr = 0;
    for (int c = 0; c < 400; c++) begin
      idle();
      host_din_valid = 1'($urandom_range(0, 1)); host_din = $urandom;
      host_dout_ready = 1'($urandom_range(0, 1));
      m = int'($urandom_range(0, 3));
      if ((m == 1 || m == 3) && !prev_wr) begin
        ft601_oe_n = 0; ft601_rd_n = 1'($urandom_range(0, 1));
      end else if (m == 2) begin
        ft601_wr_n = 0; ft601_data_in = $urandom; ft601_be_in = 4'($urandom_range(0, 15));
      end
      prev_wr = !ft601_wr_n;
      step();
    end
    idle(); step();
    ft601_oe_n = 0; ft601_rd_n = 0;
    for (int i = 0; i < 20 && rx_n > 0; i++) step();
    idle(); host_dout_ready = 1;
    for (int i = 0; i < 20 && tx_n > 0; i++) step();
    idle(); step();
    chk("rx_all_seen", 36'(rx_q.size()), 36'(0));
    chk("tx_all_seen", 36'(tx_q.size()), 36'(0));

    // 6: reset after 5 of 10 reads, with oe_n still low
    for (int i = 0; i < 10; i++) begin
      host_din_valid = 1; host_din = 32'hE00 + 32'(i); step();
    end
    host_din_valid = 0; ft601_oe_n = 0; step();
    ft601_rd_n = 0; repeat (5) step();
    #2 rst = 1;
    #1 chk_reset();
    rx_q.delete(); tx_q.delete(); rx_n = 0; tx_n = 0;
    e_under = 0; e_over = 0; e_cont = 0;
    idle();
    @(posedge clk); #1 rst = 0;
    step();
    chk("post_rst_rxf_n", 36'(ft601_rxf_n), 36'(1));
    chk("post_rst_rx_count", 36'(rx_count), 36'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
